// File: rtl/adc_channel_averager.sv
// Per-channel block averager for the ADC sample stream.
// Eight independent accumulators, a completion strobe and a registered read port.
module adc_channel_averager #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3,
  parameter int LOG2_N = 3
) (
  input  logic                 clk_2d5m,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  input  logic [CH_W-1:0]      sample_ch,
  input  logic                 clear,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 avg_rdy,
  output logic [CH_W-1:0]      avg_ch,
  output logic [DATA_W-1:0]    avg_data,
  output logic [(1<<CH_W)-1:0] ch_valid
);

  localparam int NCH = 1 << CH_W;
  localparam int AW  = DATA_W + LOG2_N;

  logic              v_q;
  logic [AW-1:0]     acc_q [NCH];
  logic [LOG2_N-1:0] cnt_q [NCH];
  logic [DATA_W-1:0] avg_q [NCH];
  logic [NCH-1:0]    ch_valid_q;
  logic              avg_rdy_q;
  logic [CH_W-1:0]   avg_ch_q;
  logic [DATA_W-1:0] avg_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              accept;
  logic              last;
  logic [AW-1:0]     sum_d;
  logic [DATA_W-1:0] avg_d;

  // Rising edge of the ready level marks exactly one new sample
  always_comb begin
    accept = sample_valid & ~v_q;
    last   = &cnt_q[sample_ch];
    sum_d  = acc_q[sample_ch] + AW'(sample_data);
    avg_d  = sum_d[AW-1:LOG2_N];
  end

  always_ff @(posedge clk_2d5m or negedge rst) begin
    if (!rst) begin
      v_q        <= 1'b0;
      ch_valid_q <= '0;
      avg_rdy_q  <= 1'b0;
      avg_ch_q   <= '0;
      avg_data_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        avg_q[i] <= '0;
      end
    end else begin
      v_q       <= sample_valid;
      avg_rdy_q <= 1'b0;
      if (clear) begin
        ch_valid_q <= '0;
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
        for (int i = 0; i < NCH; i++) begin
          acc_q[i] <= '0;
          cnt_q[i] <= '0;
          avg_q[i] <= '0;
        end
      end else begin
        rd_data_q  <= avg_q[rd_ch];
        rd_valid_q <= ch_valid_q[rd_ch];
        if (accept) begin
          if (last) begin
            avg_q[sample_ch]      <= avg_d;
            acc_q[sample_ch]      <= '0;
            cnt_q[sample_ch]      <= '0;
            ch_valid_q[sample_ch] <= 1'b1;
            avg_rdy_q             <= 1'b1;
            avg_ch_q              <= sample_ch;
            avg_data_q            <= avg_d;
          end else begin
            acc_q[sample_ch] <= sum_d;
            cnt_q[sample_ch] <= cnt_q[sample_ch] + 1'b1;
          end
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign avg_rdy  = avg_rdy_q;
  assign avg_ch   = avg_ch_q;
  assign avg_data = avg_data_q;
  assign ch_valid = ch_valid_q;

endmodule
